pipeline_front_regs: RTL and testbench
======================================

// Module: pipeline_front_regs
// PURPOSE
//   Consumer of the hazard unit's stall/flush outputs in the 5-stage MIPS pipeline. Owns the
//   PC register, the fetch->decode (IF/ID) register and the decode->execute (ID/EX) register.
//   Applies stall_fetch/stall_decode (hold), branch redirect (IF/ID flush) and clear_exe
//   (ID/EX bubble). Also keeps saturating stall/flush event counters for performance debug.
// PARAMETERS
//   RESET_PC  32'h0000_0000  PC value loaded on reset
//   CTRL_W    12             width of the packed decode-stage control bundle
//   CNT_W     32             width of the stall and flush event counters
// PORTS
//   clk                  in   1       pipeline clock, all state on rising edge
//   rst                  in   1       asynchronous, active-high reset
//   stall_fetch          in   1       hold PC
//   stall_decode         in   1       hold IF/ID
//   clear_exe            in   1       load bubble into ID/EX
//   pc_src_decode        in   1       taken branch/jump resolved in decode
//   branch_target_decode in   32      redirect target
//   instr_fetch          in   32      instruction-memory read data for pc_fetch
//   pc_fetch             out  32      current PC (instruction-memory address)
//   instr_decode         out  32      IF/ID instruction
//   pc_plus4_decode      out  32      IF/ID PC+4
//   valid_decode         out  1       IF/ID holds a real instruction
//   rs_decode,rt_decode,rd_decode  in 5 each   register specifiers from decoder
//   rd1_decode,rd2_decode          in 32 each  register-file read data
//   imm_decode           in   32      sign/zero-extended immediate
//   ctrl_decode          in   CTRL_W  control bundle from main decoder
//   rs_exe,rt_exe,rd_exe out  5 each  ID/EX specifiers (feed hazard unit)
//   rd1_exe,rd2_exe      out  32 each ID/EX operands
//   imm_exe              out  32      ID/EX immediate
//   ctrl_exe             out  CTRL_W  ID/EX control bundle
//   valid_exe            out  1       ID/EX holds a real instruction
//   stall_count          out  CNT_W   cycles with stall_decode=1
//   flush_count          out  CNT_W   accepted redirects
// BEHAVIOUR
//   Reset (async, immediate, independent of clk): pc_fetch=RESET_PC; every other output 0.
//   redirect = pc_src_decode & ~stall_decode  (redirect ignored while decode is stalled:
//     branch operands are not yet valid).
//   PC, per edge: stall_fetch -> hold; else redirect -> branch_target_decode;
//     else pc_fetch+4, wraps mod 2^32 (32'hFFFF_FFFC -> 0).
//     stall_fetch=1 with redirect=1 -> PC holds; redirect is re-evaluated next cycle.
//   IF/ID, per edge: stall_decode -> hold all fields; else redirect -> bubble
//     (instr_decode=0 i.e. sll $0 nop, pc_plus4_decode=0, valid_decode=0);
//     else instr_decode<=instr_fetch, pc_plus4_decode<=pc_fetch+4, valid_decode<=1.
//   ID/EX, per edge: clear_exe -> bubble (all fields 0, ctrl_exe=0, valid_exe=0);
//     else capture all *_decode inputs, valid_exe<=valid_decode.
//     ID/EX never stalls; clear_exe has priority over capture.
//   Latency: one cycle per stage; instr at pc_fetch reaches instr_decode at edge N+1 and
//     rs/rt/rd_exe etc. at edge N+2 when no stall/clear.
//   stall_count: +1 each edge with stall_decode=1. flush_count: +1 each edge with redirect=1.
//     Both saturate at all-ones (no wrap). Reset to 0.
//   ctrl_decode=0 must encode "no register write, no memory write"; bubbles are side-effect free.
//   Reset asserted mid-stall or mid-redirect: all state returns to reset values and
//     counters clear; first post-reset fetch is from RESET_PC.
// TESTING
//   Free run from reset, instr_fetch=pc: pc_fetch 0,4,8; instr_decode 0,4 one edge later; valid_decode 1.
//   stall_fetch=stall_decode=clear_exe=1 for 2 cycles at pc=8 -> pc_fetch holds 8, instr_decode holds 4,
//     valid_exe=0 both cycles, stall_count=2.
//   pc_src_decode=1, target=0x40, no stall -> pc_fetch=0x40, valid_decode=0, instr_decode=0, flush_count=1.
//   pc_src_decode=1 with stall_decode=1 -> PC and IF/ID hold, flush_count unchanged.
//   PC forced to 0xFFFF_FFFC via redirect, then free run -> pc_fetch=0; 2^CNT_W stall cycles -> stall_count saturates.
//   Assert rst between edges mid-stall -> pc_fetch=RESET_PC and all other outputs 0 before the next edge.

Source files
------------

// File: rtl/pipeline_front_regs_if.sv
// Bundle of hazard-unit, fetch and decode signals around the PC, IF/ID and ID/EX registers.
// master drives the stall/redirect/decode inputs; slave is the register block.
interface pipeline_front_regs_if #(
   parameter int CTRL_W = 12,
   parameter int CNT_W  = 32
);
   logic              stall_fetch;
   logic              stall_decode;
   logic              clear_exe;
   logic              pc_src_decode;
   logic [31:0]       branch_target_decode;
   logic [31:0]       instr_fetch;
   logic [31:0]       pc_fetch;
   logic [31:0]       instr_decode;
   logic [31:0]       pc_plus4_decode;
   logic              valid_decode;
   logic [4:0]        rs_decode;
   logic [4:0]        rt_decode;
   logic [4:0]        rd_decode;
   logic [31:0]       rd1_decode;
   logic [31:0]       rd2_decode;
   logic [31:0]       imm_decode;
   logic [CTRL_W-1:0] ctrl_decode;
   logic [4:0]        rs_exe;
   logic [4:0]        rt_exe;
   logic [4:0]        rd_exe;
   logic [31:0]       rd1_exe;
   logic [31:0]       rd2_exe;
   logic [31:0]       imm_exe;
   logic [CTRL_W-1:0] ctrl_exe;
   logic              valid_exe;
   logic [CNT_W-1:0]  stall_count;
   logic [CNT_W-1:0]  flush_count;

   modport master (
      output stall_fetch, stall_decode, clear_exe, pc_src_decode, branch_target_decode,
             instr_fetch, rs_decode, rt_decode, rd_decode, rd1_decode, rd2_decode,
             imm_decode, ctrl_decode,
      input  pc_fetch, instr_decode, pc_plus4_decode, valid_decode, rs_exe, rt_exe,
             rd_exe, rd1_exe, rd2_exe, imm_exe, ctrl_exe, valid_exe, stall_count,
             flush_count
   );

   modport slave (
      input  stall_fetch, stall_decode, clear_exe, pc_src_decode, branch_target_decode,
             instr_fetch, rs_decode, rt_decode, rd_decode, rd1_decode, rd2_decode,
             imm_decode, ctrl_decode,
      output pc_fetch, instr_decode, pc_plus4_decode, valid_decode, rs_exe, rt_exe,
             rd_exe, rd1_exe, rd2_exe, imm_exe, ctrl_exe, valid_exe, stall_count,
             flush_count
   );
endinterface

// File: rtl/pipeline_front_regs.sv
// PC, IF/ID and ID/EX pipeline registers with hazard-unit stall/flush/bubble control
// and saturating stall/flush event counters.
module pipeline_front_regs #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CTRL_W   = 12,
   parameter int          CNT_W    = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   pipeline_front_regs_if.slave  bus
);

   logic              redirect;
   logic [31:0]       pc_q;
   logic [31:0]       pc_plus4;
   logic [31:0]       instr_d_q;
   logic [31:0]       pc_plus4_d_q;
   logic              valid_d_q;
   logic [4:0]        rs_e_q;
   logic [4:0]        rt_e_q;
   logic [4:0]        rd_e_q;
   logic [31:0]       rd1_e_q;
   logic [31:0]       rd2_e_q;
   logic [31:0]       imm_e_q;
   logic [CTRL_W-1:0] ctrl_e_q;
   logic              valid_e_q;
   logic [CNT_W-1:0]  stall_cnt_q;
   logic [CNT_W-1:0]  flush_cnt_q;

   // Branch operands are not valid while decode is stalled, so the redirect waits.
   assign redirect = bus.pc_src_decode & ~bus.stall_decode;
   assign pc_plus4 = pc_q + 32'd4;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q <= RESET_PC;
      end else if (!bus.stall_fetch) begin
         pc_q <= redirect ? bus.branch_target_decode : pc_plus4;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_d_q    <= '0;
         pc_plus4_d_q <= '0;
         valid_d_q    <= 1'b0;
      end else if (!bus.stall_decode) begin
         if (redirect) begin
            instr_d_q    <= '0;
            pc_plus4_d_q <= '0;
            valid_d_q    <= 1'b0;
         end else begin
            instr_d_q    <= bus.instr_fetch;
            pc_plus4_d_q <= pc_plus4;
            valid_d_q    <= 1'b1;
         end
      end
   end

   // ID/EX never stalls; an all-zero bubble carries ctrl=0, i.e. no register or memory write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rs_e_q    <= '0;
         rt_e_q    <= '0;
         rd_e_q    <= '0;
         rd1_e_q   <= '0;
         rd2_e_q   <= '0;
         imm_e_q   <= '0;
         ctrl_e_q  <= '0;
         valid_e_q <= 1'b0;
      end else if (bus.clear_exe) begin
         rs_e_q    <= '0;
         rt_e_q    <= '0;
         rd_e_q    <= '0;
         rd1_e_q   <= '0;
         rd2_e_q   <= '0;
         imm_e_q   <= '0;
         ctrl_e_q  <= '0;
         valid_e_q <= 1'b0;
      end else begin
         rs_e_q    <= bus.rs_decode;
         rt_e_q    <= bus.rt_decode;
         rd_e_q    <= bus.rd_decode;
         rd1_e_q   <= bus.rd1_decode;
         rd2_e_q   <= bus.rd2_decode;
         imm_e_q   <= bus.imm_decode;
         ctrl_e_q  <= bus.ctrl_decode;
         valid_e_q <= valid_d_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (bus.stall_decode && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
         end
         if (redirect && (flush_cnt_q != '1)) begin
            flush_cnt_q <= flush_cnt_q + 1'b1;
         end
      end
   end

   assign bus.pc_fetch        = pc_q;
   assign bus.instr_decode    = instr_d_q;
   assign bus.pc_plus4_decode = pc_plus4_d_q;
   assign bus.valid_decode    = valid_d_q;
   assign bus.rs_exe          = rs_e_q;
   assign bus.rt_exe          = rt_e_q;
   assign bus.rd_exe          = rd_e_q;
   assign bus.rd1_exe         = rd1_e_q;
   assign bus.rd2_exe         = rd2_e_q;
   assign bus.imm_exe         = imm_e_q;
   assign bus.ctrl_exe        = ctrl_e_q;
   assign bus.valid_exe       = valid_e_q;
   assign bus.stall_count     = stall_cnt_q;
   assign bus.flush_count     = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_front_regs.sv
// Directed and randomized checks of pipeline_front_regs against a cycle-level reference model.
module tb_pipeline_front_regs;
   localparam int          CTRL_W   = 12;
   localparam int          CNT_W    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          SAT      = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pipeline_front_regs_if #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) bus ();

   pipeline_front_regs #(.RESET_PC(RESET_PC), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state
   logic [31:0] m_pc, m_instr_d, m_pcp4_d;
   logic        m_vd, m_ve;
   logic [31:0] m_rs_e, m_rt_e, m_rd_e, m_rd1_e, m_rd2_e, m_imm_e, m_ctrl_e;
   int          m_sc, m_fc;

   task automatic model_reset();
      m_pc = RESET_PC; m_instr_d = '0; m_pcp4_d = '0; m_vd = 1'b0; m_ve = 1'b0;
      m_rs_e = '0; m_rt_e = '0; m_rd_e = '0; m_rd1_e = '0; m_rd2_e = '0;
      m_imm_e = '0; m_ctrl_e = '0; m_sc = 0; m_fc = 0;
   endtask

   // One clock edge of the intended behaviour, computed from the inputs present at the edge.
   task automatic model_edge();
      logic        redir;
      logic [31:0] old_pc;
      logic        old_vd;
      redir  = bus.pc_src_decode && !bus.stall_decode;
      old_pc = m_pc;
      old_vd = m_vd;
      if (bus.clear_exe) begin
         m_rs_e = '0; m_rt_e = '0; m_rd_e = '0; m_rd1_e = '0; m_rd2_e = '0;
         m_imm_e = '0; m_ctrl_e = '0; m_ve = 1'b0;
      end else begin
         m_rs_e = 32'(bus.rs_decode); m_rt_e = 32'(bus.rt_decode); m_rd_e = 32'(bus.rd_decode);
         m_rd1_e = bus.rd1_decode; m_rd2_e = bus.rd2_decode; m_imm_e = bus.imm_decode;
         m_ctrl_e = 32'(bus.ctrl_decode); m_ve = old_vd;
      end
      if (!bus.stall_decode) begin
         if (redir) begin
            m_instr_d = '0; m_pcp4_d = '0; m_vd = 1'b0;
         end else begin
            m_instr_d = bus.instr_fetch; m_pcp4_d = old_pc + 32'd4; m_vd = 1'b1;
         end
      end
      if (!bus.stall_fetch) m_pc = redir ? bus.branch_target_decode : old_pc + 32'd4;
      if (bus.stall_decode && m_sc < SAT) m_sc++;
      if (redir && m_fc < SAT) m_fc++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("pc_fetch", bus.pc_fetch, m_pc);
      chk("instr_decode", bus.instr_decode, m_instr_d);
      chk("pc_plus4_decode", bus.pc_plus4_decode, m_pcp4_d);
      chk("valid_decode", 32'(bus.valid_decode), 32'(m_vd));
      chk("rs_exe", 32'(bus.rs_exe), m_rs_e);
      chk("rt_exe", 32'(bus.rt_exe), m_rt_e);
      chk("rd_exe", 32'(bus.rd_exe), m_rd_e);
      chk("rd1_exe", bus.rd1_exe, m_rd1_e);
      chk("rd2_exe", bus.rd2_exe, m_rd2_e);
      chk("imm_exe", bus.imm_exe, m_imm_e);
      chk("ctrl_exe", 32'(bus.ctrl_exe), m_ctrl_e);
      chk("valid_exe", 32'(bus.valid_exe), 32'(m_ve));
      chk("stall_count", 32'(bus.stall_count), 32'(m_sc));
      chk("flush_count", 32'(bus.flush_count), 32'(m_fc));
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) model_reset(); else model_edge();
      #1;
      check_all();
   endtask

   task automatic set_ctl(input logic sf, input logic sd, input logic ce, input logic ps,
                          input logic [31:0] tgt);
      bus.stall_fetch = sf; bus.stall_decode = sd; bus.clear_exe = ce;
      bus.pc_src_decode = ps; bus.branch_target_decode = tgt;
   endtask

   task automatic rand_decode();
      logic [31:0] r;
      r = $urandom; bus.rs_decode = r[4:0]; bus.rt_decode = r[9:5]; bus.rd_decode = r[14:10];
      r = $urandom; bus.ctrl_decode = r[CTRL_W-1:0];
      bus.rd1_decode = $urandom; bus.rd2_decode = $urandom; bus.imm_decode = $urandom;
   endtask

   initial begin
      set_ctl(1'b0, 1'b0, 1'b0, 1'b0, '0);
      bus.instr_fetch = '0;
      rand_decode();
      model_reset();
      #1;
      check_all();
      tick();
      @(negedge clk) rst = 1'b0;

      // Free run with instr_fetch equal to the address it was fetched from
      for (int i = 0; i < 2; i++) begin
         bus.instr_fetch = m_pc;
         rand_decode();
         tick();
      end
      chk("free_run_pc", bus.pc_fetch, 32'd8);
      chk("free_run_instr", bus.instr_decode, 32'd4);

      // Full stall plus bubble for two cycles
      set_ctl(1'b1, 1'b1, 1'b1, 1'b0, '0);
      bus.instr_fetch = m_pc;
      tick();
      tick();
      chk("stall_pc_hold", bus.pc_fetch, 32'd8);
      chk("stall_instr_hold", bus.instr_decode, 32'd4);
      chk("stall_count_2", 32'(bus.stall_count), 32'd2);

      // Accepted redirect
      set_ctl(1'b0, 1'b0, 1'b0, 1'b1, 32'h40);
      tick();
      chk("redirect_pc", bus.pc_fetch, 32'h40);
      chk("redirect_valid_decode", 32'(bus.valid_decode), 32'd0);
      chk("redirect_flush_count", 32'(bus.flush_count), 32'd1);

      // Redirect ignored while decode stalled
      set_ctl(1'b1, 1'b1, 1'b0, 1'b1, 32'h80);
      tick();
      chk("ignored_redirect_pc", bus.pc_fetch, 32'h40);
      chk("ignored_redirect_flush", 32'(bus.flush_count), 32'd1);

      // PC wrap from the top of the address space
      set_ctl(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
      tick();
      set_ctl(1'b0, 1'b0, 1'b0, 1'b0, '0);
      bus.instr_fetch = m_pc;
      tick();
      chk("pc_wrap", bus.pc_fetch, 32'h0);
      chk("pc_plus4_wrap", bus.pc_plus4_decode, 32'h0);

      // Stall counter saturation
      set_ctl(1'b1, 1'b1, 1'b0, 1'b0, '0);
      for (int i = 0; i < SAT + 4; i++) tick();
      chk("stall_count_sat", 32'(bus.stall_count), 32'(SAT));

      // Randomized traffic
      for (int i = 0; i < 300; i++) begin
         logic [31:0] r;
         r = $urandom;
         set_ctl($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0, {r[31:2], 2'b00});
         bus.instr_fetch = $urandom;
         rand_decode();
         tick();
      end
      chk("flush_count_sat", 32'(bus.flush_count), 32'(SAT));

      // Asynchronous reset between edges, mid-stall and mid-redirect
      set_ctl(1'b1, 1'b1, 1'b0, 1'b1, 32'h100);
      tick();
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_all();
      @(negedge clk) rst = 1'b0;
      set_ctl(1'b0, 1'b0, 1'b0, 1'b0, '0);
      bus.instr_fetch = 32'hDEAD_BEEF;
      tick();
      chk("post_reset_pc", bus.pc_fetch, RESET_PC + 32'd4);
      chk("post_reset_instr", bus.instr_decode, 32'hDEAD_BEEF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
